// File: rtl/restoring_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations per division.
// Optional div_by_zero result flag is built when DIV_BY_ZERO_FLAG_EN is defined.
module restoring_div_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
`ifdef DIV_BY_ZERO_FLAG_EN
   ,
   output logic             div_by_zero
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] q_next;
   logic             accept;
   logic             last_iter;

   assign accept    = (state_reg == IDLE) && start;
   assign last_iter = (state_reg == RUN) && (cnt_reg == CNT_W'(WIDTH - 1));

   // One restoring step: shift {A,Q}, trial-subtract M, keep the difference only if non-negative.
   always_comb begin
      a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      trial   = a_shift - {1'b0, m_reg};
      q_next  = q_reg << 1;
      if (trial[WIDTH]) begin
         a_next    = a_shift;
         q_next[0] = 1'b0;
      end else begin
         a_next    = trial;
         q_next[0] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         q_reg     <= '0;
         m_reg     <= '0;
         cnt_reg   <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (accept) begin
         a_reg   <= '0;
         q_reg   <= dividend;
         m_reg   <= divisor;
         cnt_reg <= '0;
      end else if (state_reg == RUN) begin
         a_reg   <= a_next;
         q_reg   <= q_next;
         cnt_reg <= cnt_reg + CNT_W'(1);
         if (last_iter) begin
            quotient  <= q_next;
            remainder <= a_next[WIDTH-1:0];
         end
      end
   end

`ifdef DIV_BY_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_by_zero <= 1'b0;
      end else if (last_iter) begin
         div_by_zero <= (m_reg == '0);
      end
   end
`endif

endmodule

// File: tb/tb_restoring_div_seq.sv
// Self-checking bench for restoring_div_seq (WIDTH=4) against an arithmetic reference model.
// Define DIV_BY_ZERO_FLAG_EN to also check the div_by_zero flag.
module tb_restoring_div_seq;

   localparam int WIDTH = 4;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
`ifdef DIV_BY_ZERO_FLAG_EN
   logic             div_by_zero;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   restoring_div_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef DIV_BY_ZERO_FLAG_EN
      ,
      .div_by_zero (div_by_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain unsigned division; a zero divisor gives all-ones quotient and the dividend back.
   function automatic void ref_div(input int a, input int b, output int q, output int r);
      if (b == 0) begin
         q = MAXV;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Runs one division from IDLE; reports result, edges counted including the accepting edge,
   // number of busy cycles observed and whether the cycle budget ran out.
   task automatic run_div(input int a, input int b, output int q, output int r,
                          output int edges, output int busy_cnt, output bit timeout);
      @(negedge clk);
      while (busy || done) @(negedge clk);
      dividend = WIDTH'(a);
      divisor  = WIDTH'(b);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      edges    = 1;
      busy_cnt = 0;
      while (!done && edges < 20) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         edges++;
      end
      timeout = !done;
      q = int'(quotient);
      r = int'(remainder);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, quotient, remainder} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%0b done=%0b q=%0d r=%0d, required all 0",
                  busy, done, quotient, remainder);
      end
`ifdef DIV_BY_ZERO_FLAG_EN
      n_checks++;
      if (div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dbz: got %0b, required 0", div_by_zero);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int q, r, edges, bc;
      bit to;
      run_div(13, 4, q, r, edges, bc, to);
      n_checks++;
      if (to || edges != 5) begin
         n_fail++;
         $display("FAIL basic_latency: done after %0d edges (timeout=%0b), required 5", edges, to);
      end
      n_checks++;
      if (bc != 4) begin
         n_fail++;
         $display("FAIL basic_busy: busy for %0d cycles, required 4", bc);
      end
      n_checks++;
      if (q != 3 || r != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: q=%0d r=%0d busy=%0b, required q=3 r=1 busy=0", q, r, busy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done_pulse: done=%0b one cycle later, required 0", done);
      end
      $display("basic 13/4 -> q=%0d r=%0d edges=%0d busy_cycles=%0d", q, r, edges, bc);
   endtask

   task automatic test_vectors();
      int va[4] = '{15, 7, 0, 11};
      int vb[4] = '{1, 9, 5, 0};
      int eq[4] = '{15, 0, 0, 15};
      int er[4] = '{0, 7, 0, 11};
      int q, r, edges, bc;
      bit to;
      for (int i = 0; i < 4; i++) begin
         run_div(va[i], vb[i], q, r, edges, bc, to);
         n_checks++;
         if (to || q != eq[i] || r != er[i]) begin
            n_fail++;
            $display("FAIL vector_%0d_%0d: q=%0d r=%0d timeout=%0b, required q=%0d r=%0d",
                     va[i], vb[i], q, r, to, eq[i], er[i]);
         end
`ifdef DIV_BY_ZERO_FLAG_EN
         n_checks++;
         if (div_by_zero !== (vb[i] == 0)) begin
            n_fail++;
            $display("FAIL vector_dbz_%0d_%0d: got %0b, required %0b",
                     va[i], vb[i], div_by_zero, vb[i] == 0);
         end
`endif
         $display("vector %0d/%0d -> q=%0d r=%0d", va[i], vb[i], q, r);
      end
   endtask

   task automatic test_random();
      int a, b, q, r, eq, er, edges, bc;
      bit to;
      for (int i = 0; i < 30; i++) begin
         a = int'($urandom_range(0, MAXV));
         b = (i % 7 == 0) ? 0 : int'($urandom_range(0, MAXV));
         run_div(a, b, q, r, edges, bc, to);
         ref_div(a, b, eq, er);
         n_checks++;
         if (to || edges != 5 || q != eq || r != er) begin
            n_fail++;
            $display("FAIL random_%0d_%0d: q=%0d r=%0d edges=%0d, required q=%0d r=%0d edges=5",
                     a, b, q, r, edges, eq, er);
         end
`ifdef DIV_BY_ZERO_FLAG_EN
         n_checks++;
         if (div_by_zero !== (b == 0)) begin
            n_fail++;
            $display("FAIL random_dbz_%0d_%0d: got %0b, required %0b", a, b, div_by_zero, b == 0);
         end
`endif
         $display("random %0d/%0d -> q=%0d r=%0d", a, b, q, r);
      end
   endtask

   task automatic test_start_ignored();
      int n_done = 0;
      bit bad_hold = 1'b0;
      @(negedge clk);
      while (busy || done) @(negedge clk);
      dividend = 4'd9;
      divisor  = 4'd2;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      @(negedge clk);
      dividend = 4'd14;
      divisor  = 4'd3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            n_checks++;
            if (quotient !== 4'd4 || remainder !== 4'd1) begin
               n_fail++;
               $display("FAIL ignore_result: q=%0d r=%0d, required q=4 r=1", quotient, remainder);
            end
         end else if (n_done > 0 && (quotient !== 4'd4 || remainder !== 4'd1)) begin
            bad_hold = 1'b1;
         end
      end
      n_checks++;
      if (n_done != 1 || bad_hold) begin
         n_fail++;
         $display("FAIL ignore_single_done: %0d done pulses, hold_broken=%0b, required 1 and 0",
                  n_done, bad_hold);
      end
      $display("start-during-run 9/2 (+14/3 ignored) -> q=%0d r=%0d done_pulses=%0d",
               quotient, remainder, n_done);
   endtask

   task automatic test_reset_mid_run();
      int q, r, edges, bc, n_done = 0;
      bit to;
      @(negedge clk);
      while (busy || done) @(negedge clk);
      dividend = 4'd13;
      divisor  = 4'd4;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, quotient, remainder} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset_async: busy=%0b done=%0b q=%0d r=%0d, required all 0",
                  busy, done, quotient, remainder);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      n_checks++;
      if (n_done != 0) begin
         n_fail++;
         $display("FAIL midrun_no_done: %0d done pulses, required 0", n_done);
      end
      run_div(6, 4, q, r, edges, bc, to);
      n_checks++;
      if (to || q != 1 || r != 2) begin
         n_fail++;
         $display("FAIL midrun_after_reset: q=%0d r=%0d timeout=%0b, required q=1 r=2", q, r, to);
      end
      $display("reset mid-run 13/4 aborted, then 6/4 -> q=%0d r=%0d", q, r);
   endtask

   task automatic test_back_to_back();
      int prev = -1;
      int n_done = 0;
      @(negedge clk);
      while (busy || done) @(negedge clk);
      dividend = 4'd15;
      divisor  = 4'd4;
      start    = 1'b1;
      for (int i = 0; i < 40 && n_done < 4; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            n_checks++;
            if (quotient !== 4'd3 || remainder !== 4'd3) begin
               n_fail++;
               $display("FAIL b2b_result: q=%0d r=%0d, required q=3 r=3", quotient, remainder);
            end
            if (prev >= 0) begin
               n_checks++;
               if (cyc - prev != 6) begin
                  n_fail++;
                  $display("FAIL b2b_period: %0d cycles between done pulses, required 6", cyc - prev);
               end
            end
            $display("back-to-back 15/4 done at cycle %0d -> q=%0d r=%0d", cyc, quotient, remainder);
            prev = cyc;
         end
      end
      start = 1'b0;
      n_checks++;
      if (n_done != 4) begin
         n_fail++;
         $display("FAIL b2b_count: %0d done pulses in budget, required 4", n_done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_random();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
